// File: rtl/arm_defs.sv
// arm_defs: shared definitions for the MEM-stage SRAM sequencer
// (FSM encoding, data-segment base, SRAM geometry, word-index helper).
package arm_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_e;

   localparam logic [31:0] DATA_BASE = 32'd1024;
   localparam int          SRAM_AW   = 18;
   localparam int          SRAM_DW   = 16;

   // Word index relative to the data segment; wraps modulo 2^32 like the ALU.
   function automatic logic [29:0] word_index(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
      return 30'((byte_addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: counts 0..max-1 inside one SRAM phase and flags the
// final cycle. clear restarts the count, so every state entry begins at 0.
module sram_phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic [3:0] max,
   output logic       last
);

   logic [3:0] cnt;

   assign last = (cnt == max - 4'd1);

   // Phase counter: restart on clear, wrap after the last cycle
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking (<=) so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst || clear || last) begin
         cnt <= 4'd0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit MEM-stage word access into two timed
// 16-bit phases on the asynchronous SRAM; ready low freezes the pipeline.
// Optional feature: define SRAM_LASTREAD_BUF_EN for a one-entry last-read
// buffer that answers a repeated read without touching the SRAM.
module sram_controller #(
   parameter int unsigned PHASE_CYCLES = 2,
   parameter logic [31:0] DATA_BASE    = arm_defs::DATA_BASE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic [31:0]                  addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata,
   output logic                         ready,
   output logic [arm_defs::SRAM_AW-1:0] sram_addr,
   inout  wire  [arm_defs::SRAM_DW-1:0] sram_dq,
   output logic                         sram_we_n,
   output logic                         sram_ce_n,
   output logic                         sram_oe_n,
   output logic                         sram_ub_n,
   output logic                         sram_lb_n
);

   import arm_defs::*;

   sram_state_e state, next_state;
   logic        phase_last;
   logic        timer_clear;
   logic        hit;
   logic        accept;
   logic [29:0] req_idx;
   logic        req_write_q;
   logic [16:0] idx_q;
   logic [31:0] wdata_q;

   assign req_idx = word_index(addr, DATA_BASE);
   assign accept  = (wr_en | rd_en) & ~hit;

   sram_phase_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (timer_clear),
      .max   (4'(PHASE_CYCLES)),
      .last  (phase_last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, phase-counter restart and pipeline freeze
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      next_state = state;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = ~accept;
            if (accept) next_state = LOW;
         end
         LOW:  if (phase_last) next_state = HIGH;
         HIGH: if (phase_last) next_state = DONE;
         DONE: begin
            ready      = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      timer_clear = (next_state != state) || (state == IDLE) || (state == DONE);
   end

   // Latch the accepted request; the pipeline copy may change once frozen
   always_ff @(posedge clk) begin
      // NOTE: pure data registers are not reset; they are only read after
      // an accept has loaded them, so a reset would just cost routing.
      if (state == IDLE && accept) begin
         req_write_q <= wr_en;
         idx_q       <= req_idx[16:0];
         wdata_q     <= wdata;
      end
   end

   // SRAM address and write strobe, changed only on phase entry
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_addr <= '0;
         sram_we_n <= 1'b1;
      end else if (next_state != state) begin
         case (next_state)
            LOW: begin
               sram_addr <= {req_idx[16:0], 1'b0};
               sram_we_n <= ~wr_en;
            end
            HIGH:    sram_addr <= {idx_q, 1'b1};
            default: sram_we_n <= 1'b1;
         endcase
      end
   end

   // Capture each read half on the last cycle of its phase
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (!req_write_q && phase_last) begin
         if (state == LOW) begin
            rdata[15:0] <= sram_dq;
         end else if (state == HIGH) begin
            rdata[31:16] <= sram_dq;
         end
      end
   end

   assign sram_dq = (req_write_q && state == LOW)  ? wdata_q[15:0]  :
                    (req_write_q && state == HIGH) ? wdata_q[31:16] :
                    {SRAM_DW{1'bz}};

   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_oe_n = ~sram_we_n;

`ifdef SRAM_LASTREAD_BUF_EN
   logic        buf_valid;
   logic [29:0] buf_idx;
   logic [29:0] pend_idx;

   assign hit = buf_valid && rd_en && !wr_en && (buf_idx == req_idx);

   // Remember the index of the last completed read; any write invalidates it
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
      end else if (state == IDLE && accept) begin
         pend_idx <= req_idx;
         if (wr_en) buf_valid <= 1'b0;
      end else if (state == DONE && !req_write_q) begin
         buf_valid <= 1'b1;
         buf_idx   <= pend_idx;
      end
   end
`else
   logic unused_idx_hi;

   assign hit           = 1'b0;
   assign unused_idx_hi = ^req_idx[29:17];
`endif

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller against a 64-word
// SRAM model. Buffer scenarios follow SRAM_LASTREAD_BUF_EN when defined.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_ub_n;
   logic        sram_lb_n;

   logic [15:0] mem [64];
   int          n_checks = 0;
   int          n_pass   = 0;

   sram_controller #(.PHASE_CYCLES(2), .DATA_BASE(32'd1024)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .sram_we_n (sram_we_n),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n)
   );

   always #5 clk = ~clk;

   // An undriven bus floats high, so a released controller reads as 16'hFFFF.
   pullup (sram_dq);

   // SRAM model: drives only while an access is in flight so the idle bus
   // shows whether the controller has released it.
   assign sram_dq = (!sram_ce_n && !sram_oe_n && !ready) ? mem[sram_addr[5:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
   end

   // Present one request at a negedge and follow it to completion.
   task automatic run_access(input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int busy, output int we_low,
                             output int addr_chg, output int oe_bad,
                             output logic done);
      logic [17:0] last_addr;
      busy = 0; we_low = 0; addr_chg = 0; oe_bad = 0; done = 1'b0;
      @(negedge clk);
      wr_en = wr; rd_en = rd; addr = a; wdata = wd;
      #1;
      last_addr = sram_addr;
      if (ready) begin
         // zero-wait answer: keep the request across an edge and make sure
         // nothing started
         @(negedge clk);
         if (!ready) busy++;
         if (!sram_we_n) we_low++;
         if (sram_addr !== last_addr) addr_chg++;
         done = ready;
      end else begin
         busy = 1;
         for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (sram_oe_n !== ~sram_we_n) oe_bad++;
            if (sram_addr !== last_addr) addr_chg++;
            last_addr = sram_addr;
            if (ready) done = 1'b1;
            else       busy++;
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
      n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else n_pass++;
      n_checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n: got %b want 1", sram_we_n); else n_pass++;
      n_checks++; if (sram_dq !== 16'hFFFF) $display("FAIL reset_dq_released: got %h want ffff (floating)", sram_dq); else n_pass++;
      n_checks++; if (sram_addr !== 18'h0) $display("FAIL reset_addr: got %h want 0", sram_addr); else n_pass++;
      n_checks++; if ({sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n} !== 4'b0000)
         $display("FAIL reset_ties: ce/ub/lb/oe got %b want 0000", {sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n}); else n_pass++;
   endtask

   task automatic test_write();
      int busy, we_low, addr_chg, oe_bad; logic done;
      run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (done !== 1'b1) $display("FAIL write_done: got %b want 1", done); else n_pass++;
      n_checks++; if (busy !== 5) $display("FAIL write_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (we_low !== 4) $display("FAIL write_we_low: got %0d want 4", we_low); else n_pass++;
      n_checks++; if (oe_bad !== 0) $display("FAIL write_oe: %0d cycles with oe_n != ~we_n, want 0", oe_bad); else n_pass++;
      n_checks++; if (mem[0] !== 16'hBEEF) $display("FAIL write_mem0: got %h want beef", mem[0]); else n_pass++;
      n_checks++; if (mem[1] !== 16'hDEAD) $display("FAIL write_mem1: got %h want dead", mem[1]); else n_pass++;
      n_checks++; if (rdata !== 32'h0) $display("FAIL write_rdata: got %h want 00000000", rdata); else n_pass++;
   endtask

   task automatic test_read();
      int busy, we_low, addr_chg, oe_bad; logic done;
      run_access(1'b0, 1'b1, 32'd1024, 32'h0, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (done !== 1'b1) $display("FAIL read_done: got %b want 1", done); else n_pass++;
      n_checks++; if (busy !== 5) $display("FAIL read_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (we_low !== 0) $display("FAIL read_we_low: got %0d want 0", we_low); else n_pass++;
      n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", rdata); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int busy, we_low, addr_chg, oe_bad; logic done;
      // issued in the cycle right after the previous DONE
      run_access(1'b0, 1'b1, 32'd1028, 32'h0, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else n_pass++;
      n_checks++; if (busy !== 5) $display("FAIL b2b_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (rdata !== 32'h56781234) $display("FAIL b2b_rdata: got %h want 56781234", rdata); else n_pass++;
   endtask

   task automatic test_write_read_collision();
      int busy, we_low, addr_chg, oe_bad; logic done;
      run_access(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (done !== 1'b1) $display("FAIL both_done: got %b want 1", done); else n_pass++;
      n_checks++; if (busy !== 5) $display("FAIL both_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (we_low !== 4) $display("FAIL both_we_low: got %0d want 4", we_low); else n_pass++;
      n_checks++; if (rdata !== 32'h56781234) $display("FAIL both_rdata: got %h want 56781234", rdata); else n_pass++;
      n_checks++; if (mem[4] !== 16'hFFFF) $display("FAIL both_mem4: got %h want ffff", mem[4]); else n_pass++;
      n_checks++; if (mem[5] !== 16'h0000) $display("FAIL both_mem5: got %h want 0000", mem[5]); else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      wr_en = 1'b1; addr = 32'd1048; wdata = 32'hAAAA5555;   // word 6 -> halves 12/13
      @(negedge clk);                                        // cycle 1: LOW
      @(negedge clk);                                        // cycle 2: LOW
      rst = 1'b1; wr_en = 1'b0;
      @(negedge clk);                                        // cycle 3: IDLE
      n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
      n_checks++; if (sram_we_n !== 1'b1) $display("FAIL abort_we_n: got %b want 1", sram_we_n); else n_pass++;
      n_checks++; if (sram_dq !== 16'hFFFF) $display("FAIL abort_dq_released: got %h want ffff (floating)", sram_dq); else n_pass++;
      n_checks++; if (rdata !== 32'h0) $display("FAIL abort_rdata: got %h want 00000000", rdata); else n_pass++;
      n_checks++; if (mem[12] !== 16'h5555) $display("FAIL abort_mem12: got %h want 5555", mem[12]); else n_pass++;
      n_checks++; if (mem[13] !== 16'h7777) $display("FAIL abort_mem13: got %h want 7777", mem[13]); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_lastread_buf();
      int busy, we_low, addr_chg, oe_bad; logic done;
      run_access(1'b0, 1'b1, 32'd1024, 32'h0, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (busy !== 5) $display("FAIL buf_first_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL buf_first_rdata: got %h want deadbeef", rdata); else n_pass++;
      run_access(1'b0, 1'b1, 32'd1024, 32'h0, busy, we_low, addr_chg, oe_bad, done);
`ifdef SRAM_LASTREAD_BUF_EN
      n_checks++; if (busy !== 0) $display("FAIL buf_hit_busy: got %0d want 0", busy); else n_pass++;
      n_checks++; if (addr_chg !== 0) $display("FAIL buf_hit_addr: %0d address changes, want 0", addr_chg); else n_pass++;
      n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL buf_hit_rdata: got %h want deadbeef", rdata); else n_pass++;
      run_access(1'b1, 1'b0, 32'd2000, 32'h13572468, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (busy !== 5) $display("FAIL buf_write_busy: got %0d want 5", busy); else n_pass++;
      run_access(1'b0, 1'b1, 32'd1024, 32'h0, busy, we_low, addr_chg, oe_bad, done);
      n_checks++; if (busy !== 5) $display("FAIL buf_after_write_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL buf_after_write_rdata: got %h want deadbeef", rdata); else n_pass++;
`else
      n_checks++; if (busy !== 5) $display("FAIL nobuf_repeat_busy: got %0d want 5", busy); else n_pass++;
      n_checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL nobuf_repeat_rdata: got %h want deadbeef", rdata); else n_pass++;
`endif
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[2]  = 16'h1234;
      mem[3]  = 16'h5678;
      mem[5]  = 16'hEEEE;
      mem[13] = 16'h7777;

      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_write_read_collision();
      test_reset_mid_write();
      test_lastread_buf();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
